// File: rtl/vram_ctrl_pkg.sv
// Shared definitions for the framebuffer VRAM controller: geometry, sizing and FSM encoding.
package vram_ctrl_pkg;

  localparam int unsigned FbWidth   = 768;
  localparam int unsigned FbHeight  = 896;
  localparam int unsigned WordBits  = 32;
  // One bit per pixel, packed 32 pixels per word.
  localparam int unsigned VramWords = FbWidth * FbHeight / WordBits;
  localparam int unsigned AddrWidth = 15;

  typedef enum logic [2:0] {
    StIdle,
    StVidRd,
    StCpuRd,
    StCpuWr,
    StCpuHold
  } state_e;

endpackage

// File: rtl/vram_ctrl_if.sv
// CPU (Xbus framebuffer) and video scan-out ports of the VRAM controller.
interface vram_ctrl_if import vram_ctrl_pkg::*; #(
  parameter int unsigned ADDR_W = AddrWidth
);
  logic [ADDR_W-1:0] vram_addr;
  logic [31:0]       vram_data_out;
  logic [31:0]       vram_data_in;
  logic              vram_req;
  logic              vram_write;
  logic              vram_ready;
  logic              vram_done;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_req;
  logic [31:0]       vga_data;
  logic              vga_ready;
  logic              vga_overrun;

  modport master (
    output vram_addr, vram_data_out, vram_req, vram_write, vga_addr, vga_req,
    input  vram_data_in, vram_ready, vram_done, vga_data, vga_ready, vga_overrun
  );

  modport slave (
    input  vram_addr, vram_data_out, vram_req, vram_write, vga_addr, vga_req,
    output vram_data_in, vram_ready, vram_done, vga_data, vga_ready, vga_overrun
  );
endinterface

// File: rtl/vram_ram.sv
// Single-port synchronous RAM with write enable and registered read; storage is not reset.
module vram_ram #(
  parameter int unsigned Words = 21504,
  parameter int unsigned AddrW = 15,
  parameter int unsigned DataW = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata
);
  logic [DataW-1:0] mem [Words];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/vram_ctrl.sv
// VRAM controller arbitrating CPU read/write against video scan-out fetches (video has priority).
module vram_ctrl import vram_ctrl_pkg::*; #(
  parameter int unsigned VRAM_WORDS = VramWords,
  parameter int unsigned ADDR_W     = AddrWidth
) (
  input logic        clk,
  input logic        reset,
  vram_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  logic              vid_pend_q, vid_pend_d, vid_eff;
  logic [ADDR_W-1:0] vid_addr_q, vid_eff_addr, cpu_addr_q, ram_addr_raw, ram_addr;
  logic [31:0]       cpu_wdata_q, ram_rdata, rd_word, vga_data_q, cpu_rdata_q;
  logic              rd_oor_q, ram_we, overrun_q;
  logic              vid_rd, cpu_rd, cpu_wr;

  function automatic logic in_range(logic [ADDR_W-1:0] a);
    return 32'(a) < VRAM_WORDS;
  endfunction

  assign vid_eff      = vid_pend_q | bus.vga_req;
  assign vid_eff_addr = bus.vga_req ? bus.vga_addr : vid_addr_q;

  // Response states are squashed by a reset arriving in the same cycle.
  assign vid_rd = (state_q == StVidRd) && !reset;
  assign cpu_rd = (state_q == StCpuRd) && !reset;
  assign cpu_wr = (state_q == StCpuWr) && !reset;

  always_comb begin
    state_d      = state_q;
    vid_pend_d   = vid_pend_q | bus.vga_req;
    ram_addr_raw = cpu_addr_q;
    unique case (state_q)
      StIdle: begin
        if (vid_eff) begin
          state_d      = StVidRd;
          ram_addr_raw = vid_eff_addr;
          vid_pend_d   = 1'b0;
        end else if (bus.vram_write) begin
          state_d = StCpuWr;
        end else if (bus.vram_req) begin
          state_d      = StCpuRd;
          ram_addr_raw = bus.vram_addr;
        end
      end
      StVidRd:          state_d = StIdle;
      StCpuRd, StCpuWr: state_d = StCpuHold;
      StCpuHold: begin
        if (!bus.vram_req && !bus.vram_write) state_d = StIdle;
      end
      default:          state_d = StIdle;
    endcase
  end

  assign ram_addr = in_range(ram_addr_raw) ? ram_addr_raw : '0;
  assign ram_we   = cpu_wr && in_range(cpu_addr_q);
  assign rd_word  = rd_oor_q ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      overrun_q   <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      rd_oor_q    <= 1'b0;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      vid_pend_q <= vid_pend_d;
      if (bus.vga_req) vid_addr_q <= bus.vga_addr;
      if (bus.vga_req && vid_pend_q) overrun_q <= 1'b1;
      // Latched every idle cycle so a write deferred by video uses the address seen on entry.
      if (state_q == StIdle) begin
        cpu_addr_q  <= bus.vram_addr;
        cpu_wdata_q <= bus.vram_data_out;
      end
      rd_oor_q <= !in_range(ram_addr_raw);
      if (vid_rd) vga_data_q  <= rd_word;
      if (cpu_rd) cpu_rdata_q <= rd_word;
    end
  end

  vram_ram #(
    .Words (VRAM_WORDS),
    .AddrW (ADDR_W),
    .DataW (32)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cpu_wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.vram_data_in = cpu_rd ? rd_word : cpu_rdata_q;
  assign bus.vram_ready   = cpu_rd;
  assign bus.vram_done    = cpu_wr;
  assign bus.vga_data     = vid_rd ? rd_word : vga_data_q;
  assign bus.vga_ready    = vid_rd;
  assign bus.vga_overrun  = overrun_q;
endmodule

// File: tb/tb_vram_ctrl.sv
// Scoreboard bench for vram_ctrl: directed stimulus queues expected responses and cycles.
module tb_vram_ctrl;
  import vram_ctrl_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_vga[$];
  exp_t exp_rd[$];
  int   exp_done[$];

  vram_ctrl_if #(.ADDR_W(15)) bus ();

  vram_ctrl #(
    .VRAM_WORDS (VramWords),
    .ADDR_W     (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_vga(input logic [31:0] data, input int at);
    exp_t e;
    e.data = data;
    e.cyc  = at;
    exp_vga.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] data, input int at);
    exp_t e;
    e.data = data;
    e.cyc  = at;
    exp_rd.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE; level held through the response cycle plus `hold` more cycles.
  task automatic cpu_access(input bit wr, input int addr, input logic [31:0] wdata,
                            input logic [31:0] rexp, input int hold);
    bus.vram_addr     = 15'(addr);
    bus.vram_data_out = wdata;
    if (wr) begin
      bus.vram_write = 1'b1;
      exp_done.push_back(cyc + 1);
    end else begin
      bus.vram_req = 1'b1;
      push_rd(rexp, cyc + 1);
    end
    repeat (2 + hold) tick();
    bus.vram_write = 1'b0;
    bus.vram_req   = 1'b0;
    tick();
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    int   pulses;
    exp_t e;
    pulses = 0;
    if (bus.vga_ready === 1'b1) pulses++;
    if (bus.vram_ready === 1'b1) pulses++;
    if (bus.vram_done === 1'b1) pulses++;
    if (pulses != 0) check("pulse_exclusive", 32'(pulses), 1);
    if (bus.vga_ready === 1'b1) begin
      if (exp_vga.size() == 0) check("vga_ready_unexpected", 32'(bus.vga_ready), 0);
      else begin
        e = exp_vga.pop_front();
        check("vga_data", bus.vga_data, e.data);
        check("vga_cycle", cyc, e.cyc);
      end
    end
    if (bus.vram_ready === 1'b1) begin
      if (exp_rd.size() == 0) check("vram_ready_unexpected", 32'(bus.vram_ready), 0);
      else begin
        e = exp_rd.pop_front();
        check("rd_data", bus.vram_data_in, e.data);
        check("rd_cycle", cyc, e.cyc);
      end
    end
    if (bus.vram_done === 1'b1) begin
      if (exp_done.size() == 0) check("vram_done_unexpected", 32'(bus.vram_done), 0);
      else check("done_cycle", cyc, exp_done.pop_front());
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vram_ready"}, 32'(bus.vram_ready), 0);
    check({tag, "_vram_done"}, 32'(bus.vram_done), 0);
    check({tag, "_vga_ready"}, 32'(bus.vga_ready), 0);
    check({tag, "_vga_overrun"}, 32'(bus.vga_overrun), 0);
    check({tag, "_vram_data_in"}, bus.vram_data_in, 0);
    check({tag, "_vga_data"}, bus.vga_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (checks %0d)", n_total);
    $fatal(1);
  end

  initial begin
    bus.vram_addr     = '0;
    bus.vram_data_out = '0;
    bus.vram_req      = 1'b0;
    bus.vram_write    = 1'b0;
    bus.vga_addr      = '0;
    bus.vga_req       = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_outputs_zero("reset");

    // Write then read back address 0.
    cpu_access(1'b1, 0, 32'o12345670, 32'h0, 1);
    cpu_access(1'b0, 0, 32'h0, 32'o12345670, 1);

    // Preload words used below.
    cpu_access(1'b1, 5, 32'hA5A5_0005, 32'h0, 0);
    cpu_access(1'b1, 3, 32'h3333_3333, 32'h0, 0);
    cpu_access(1'b1, 7, 32'h7777_7777, 32'h0, 0);
    cpu_access(1'b1, 20, 32'h2020_2020, 32'h0, 0);
    cpu_access(1'b1, 21503, 32'hCAFE_0001, 32'h0, 0);

    // Video and write collide in IDLE: video first with old data, write done 2 cycles later.
    bus.vga_addr      = 15'd5;
    bus.vga_req       = 1'b1;
    bus.vram_addr     = 15'd5;
    bus.vram_data_out = 32'hFFFF_FFFF;
    bus.vram_write    = 1'b1;
    push_vga(32'hA5A5_0005, cyc + 1);
    exp_done.push_back(cyc + 3);
    tick();
    bus.vga_req = 1'b0;
    repeat (3) tick();
    bus.vram_write = 1'b0;
    tick();
    cpu_access(1'b0, 5, 32'h0, 32'hFFFF_FFFF, 0);

    // Read held 4 cycles past ready; video request arriving in HOLD waits for IDLE.
    bus.vram_addr = 15'd0;
    bus.vram_req  = 1'b1;
    push_rd(32'o12345670, cyc + 1);
    repeat (3) tick();
    bus.vga_addr = 15'd0;
    bus.vga_req  = 1'b1;
    push_vga(32'o12345670, cyc + 5);
    tick();
    bus.vga_req = 1'b0;
    repeat (2) tick();
    bus.vram_req = 1'b0;
    repeat (3) tick();
    check("overrun_still_clear", 32'(bus.vga_overrun), 0);

    // Out-of-range write dropped, read returns 0, neighbour intact.
    cpu_access(1'b1, 21504, 32'h1, 32'h0, 0);
    cpu_access(1'b0, 21504, 32'h0, 32'h0, 0);
    cpu_access(1'b0, 21503, 32'h0, 32'hCAFE_0001, 0);

    // Overrun: video requests to 3 (in CPU_WR) then 7 (in HOLD); single fetch of addr 7.
    bus.vram_addr     = 15'd10;
    bus.vram_data_out = 32'h1010_1010;
    bus.vram_write    = 1'b1;
    exp_done.push_back(cyc + 1);
    tick();
    bus.vga_addr = 15'd3;
    bus.vga_req  = 1'b1;
    tick();
    bus.vga_addr   = 15'd7;
    bus.vram_write = 1'b0;
    push_vga(32'h7777_7777, cyc + 2);
    tick();
    bus.vga_req = 1'b0;
    repeat (3) tick();
    check("overrun_set", 32'(bus.vga_overrun), 1);
    cpu_access(1'b0, 10, 32'h0, 32'h1010_1010, 0);

    // Reset during CPU_WR: no done, word unchanged, outputs cleared.
    bus.vram_addr     = 15'd20;
    bus.vram_data_out = 32'hDEAD_BEEF;
    bus.vram_write    = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    bus.vram_write = 1'b0;
    check_outputs_zero("post_reset");
    tick();
    cpu_access(1'b0, 20, 32'h0, 32'h2020_2020, 0);

    repeat (5) tick();
    check("vga_queue_drained", 32'(exp_vga.size()), 0);
    check("rd_queue_drained", 32'(exp_rd.size()), 0);
    check("done_queue_drained", 32'(exp_done.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
